ball_motion_ctrl: RTL and testbench

//  Frame-rate sequencer for the ball. Steps ball X/Y once per frame tick and

---
 rtl/ball_motion_ctrl_if.sv | 24 ++
 rtl/ball_motion_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ball_motion_ctrl_if.sv
// rtl/ball_motion_ctrl_if.sv - frame tick, start, collision code and ball state bundle
interface ball_motion_ctrl_if;
  logic       FrameTick;
  logic       Start;
  logic [2:0] ColOut;
  logic [9:0] XCord;
  logic [9:0] YCord;
  logic       DirX;
  logic       DirY;
  logic [7:0] Score;
  logic [3:0] Misses;
  logic       Playing;
  logic       GameOver;

  modport master (
    output FrameTick, Start, ColOut,
    input  XCord, YCord, DirX, DirY, Score, Misses, Playing, GameOver
  );

  modport slave (
    input  FrameTick, Start, ColOut,
    output XCord, YCord, DirX, DirY, Score, Misses, Playing, GameOver
  );
endinterface

// File: rtl/ball_motion_ctrl.sv
// rtl/ball_motion_ctrl.sv - frame-rate ball sequencer: step, settle, bounce/score/miss rules
module ball_motion_ctrl #(
  parameter int STEP       = 2,
  parameter int SERVE_X    = 320,
  parameter int SERVE_Y    = 232,
  parameter int NET_X      = 632,
  parameter int SETTLE     = 3,
  parameter int MAX_MISS   = 3,
  parameter int SERVE_WAIT = 60
) (
  input logic               Clk,
  input logic               Rst_n,
  ball_motion_ctrl_if.slave bus
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int FW = (SERVE_WAIT > 1) ? $clog2(SERVE_WAIT) : 1;

  localparam logic [2:0] COL_PADDLE  = 3'b001;
  localparam logic [2:0] COL_NET     = 3'b011;
  localparam logic [2:0] COL_CEILING = 3'b010;
  localparam logic [2:0] COL_FLOOR   = 3'b110;
  localparam logic [2:0] COL_BACK    = 3'b100;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SERVE,
    S_WAIT,
    S_STEP,
    S_SETTLE,
    S_CHECK,
    S_MISS,
    S_HOLD,
    S_GAMEOVER
  } state_t;

  state_t          state_q;
  logic [9:0]      x_q;
  logic [9:0]      y_q;
  logic            dirx_q;
  logic            diry_q;
  logic [7:0]      score_q;
  logic [3:0]      misses_q;
  logic            playing_q;
  logic            gameover_q;
  logic [SW-1:0]   settle_cnt_q;
  logic [FW-1:0]   frame_cnt_q;
  logic [3:0]      misses_d;

  // One axis step, clamped to the 10-bit range instead of wrapping
  function automatic logic [9:0] step_axis(input logic [9:0] v, input logic up);
    logic [10:0] sum;
    sum = {1'b0, v} + 11'(STEP);
    if (up) begin
      return sum[10] ? 10'h3FF : sum[9:0];
    end
    return (v < 10'(STEP)) ? 10'd0 : v - 10'(STEP);
  endfunction

  assign misses_d = misses_q + 4'd1;

  // Sequencer: serve, per-tick step, wait for the detector code to settle, then apply rules
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      x_q          <= 10'(SERVE_X);
      y_q          <= 10'(SERVE_Y);
      dirx_q       <= 1'b0;
      diry_q       <= 1'b0;
      score_q      <= 8'd0;
      misses_q     <= 4'd0;
      playing_q    <= 1'b0;
      gameover_q   <= 1'b0;
      settle_cnt_q <= '0;
      frame_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Start has priority; a coincident tick is simply not looked at here
          if (bus.Start) begin
            score_q  <= 8'd0;
            misses_q <= 4'd0;
            state_q  <= S_SERVE;
          end
        end
        S_SERVE: begin
          x_q       <= 10'(SERVE_X);
          y_q       <= 10'(SERVE_Y);
          dirx_q    <= 1'b0;
          diry_q    <= ~diry_q;
          playing_q <= 1'b1;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.FrameTick) begin
            state_q <= S_STEP;
          end
        end
        S_STEP: begin
          x_q          <= step_axis(x_q, dirx_q);
          y_q          <= step_axis(y_q, diry_q);
          settle_cnt_q <= '0;
          state_q      <= S_SETTLE;
        end
        S_SETTLE: begin
          // Gives the detector's posedge select and negedge code registers time to follow
          if (settle_cnt_q == SW'(SETTLE - 1)) begin
            settle_cnt_q <= '0;
            state_q      <= S_CHECK;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          // Directions are forced, not toggled, so a held stale code is harmless
          state_q <= S_WAIT;
          case (bus.ColOut)
            COL_CEILING: diry_q <= 1'b1;
            COL_FLOOR:   diry_q <= 1'b0;
            COL_BACK:    dirx_q <= 1'b1;
            COL_PADDLE: begin
              if (dirx_q) begin
                dirx_q <= 1'b0;
                if (score_q != 8'hFF) begin
                  score_q <= score_q + 8'd1;
                end
              end
            end
            COL_NET: begin
              if (x_q > 10'(NET_X)) begin
                playing_q <= 1'b0;
                state_q   <= S_MISS;
              end
            end
            default: ;
          endcase
        end
        S_MISS: begin
          misses_q <= misses_d;
          if (misses_d == 4'(MAX_MISS)) begin
            gameover_q <= 1'b1;
            state_q    <= S_GAMEOVER;
          end else begin
            frame_cnt_q <= '0;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Ball stays frozen while the pause before the next serve runs down
          if (bus.FrameTick) begin
            if (frame_cnt_q == FW'(SERVE_WAIT - 1)) begin
              frame_cnt_q <= '0;
              state_q     <= S_SERVE;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end
        S_GAMEOVER: begin
          if (bus.Start) begin
            score_q    <= 8'd0;
            misses_q   <= 4'd0;
            gameover_q <= 1'b0;
            state_q    <= S_SERVE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.XCord    = x_q;
  assign bus.YCord    = y_q;
  assign bus.DirX     = dirx_q;
  assign bus.DirY     = diry_q;
  assign bus.Score    = score_q;
  assign bus.Misses   = misses_q;
  assign bus.Playing  = playing_q;
  assign bus.GameOver = gameover_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb/tb_ball_motion_ctrl.sv - directed self-checking bench for ball_motion_ctrl
module tb_ball_motion_ctrl;

  logic Clk;
  logic Rst_n;

  ball_motion_ctrl_if bus();

  ball_motion_ctrl dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks;
  int failures;

  // Reference ball state
  int mx, my;
  bit mdx, mdy;
  int msc, mmi;
  bit mplay, mgo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sat_step(input int v, input bit up);
    if (up) return (v + 2 > 1023) ? 1023 : v + 2;
    return (v < 2) ? 0 : v - 2;
  endfunction

  task automatic model_serve();
    mx = 320; my = 232; mdx = 1'b0; mdy = ~mdy; mplay = 1'b1;
  endtask

  task automatic model_step(input logic [2:0] col);
    mx = sat_step(mx, mdx);
    my = sat_step(my, mdy);
    case (col)
      3'b010: mdy = 1'b1;
      3'b110: mdy = 1'b0;
      3'b100: mdx = 1'b1;
      3'b001: if (mdx) begin mdx = 1'b0; if (msc < 255) msc++; end
      3'b011: if (mx > 632) begin
        mplay = 1'b0;
        mmi++;
        if (mmi == 3) mgo = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".x"},   32'(bus.XCord),    32'(mx));
    check({tag, ".y"},   32'(bus.YCord),    32'(my));
    check({tag, ".dx"},  32'(bus.DirX),     32'(mdx));
    check({tag, ".dy"},  32'(bus.DirY),     32'(mdy));
    check({tag, ".sc"},  32'(bus.Score),    32'(msc));
    check({tag, ".mi"},  32'(bus.Misses),   32'(mmi));
    check({tag, ".pl"},  32'(bus.Playing),  32'(mplay));
    check({tag, ".go"},  32'(bus.GameOver), 32'(mgo));
  endtask

  task automatic pulse_tick();
    @(posedge Clk); #1 bus.FrameTick = 1'b1;
    @(posedge Clk); #1 bus.FrameTick = 1'b0;
  endtask

  task automatic settle_wait();
    repeat (8) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic tick(input logic [2:0] col);
    bus.ColOut = col;
    pulse_tick();
    settle_wait();
    if (mplay) model_step(col);
  endtask

  task automatic pulse_start();
    @(posedge Clk); #1 bus.Start = 1'b1;
    @(posedge Clk); #1 bus.Start = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic run_to_miss(input string tag);
    for (int i = 0; i < 400 && !(mdx && mx + 2 > 632); i++) tick(3'b100);
    check({tag, ".reach"}, 32'(mdx && mx + 2 > 632), 32'd1);
    tick(3'b011);
  endtask

  task automatic hold_and_serve(input string tag);
    for (int i = 0; i < 59; i++) begin
      pulse_tick();
      settle_wait();
    end
    check_all({tag, ".frozen"});
    pulse_tick();
    settle_wait();
    model_serve();
    check_all({tag, ".reserve"});
    check({tag, ".x320"}, 32'(bus.XCord), 32'd320);
    check({tag, ".y232"}, 32'(bus.YCord), 32'd232);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    mx = 320; my = 232; mdx = 0; mdy = 0; msc = 0; mmi = 0; mplay = 0; mgo = 0;
    Rst_n = 1'b0;
    bus.FrameTick = 1'b0;
    bus.Start = 1'b0;
    bus.ColOut = 3'b000;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_all("reset");
    @(posedge Clk); #1 Rst_n = 1'b1;

    // Start and tick together in IDLE: tick dropped, ball sits at serve point
    @(posedge Clk); #1 begin bus.Start = 1'b1; bus.FrameTick = 1'b1; end
    @(posedge Clk); #1 begin bus.Start = 1'b0; bus.FrameTick = 1'b0; end
    settle_wait();
    model_serve();
    check_all("start_tick");

    // First step: DirX=0 moves left, first serve toggles DirY to down
    tick(3'b000);
    check_all("step1");
    check("step1.x318", 32'(bus.XCord), 32'd318);
    check("step1.y234", 32'(bus.YCord), 32'd234);

    // Floor forces up, then a held ceiling code stays forced down
    tick(3'b110);
    check_all("floor");
    for (int i = 0; i < 3; i++) begin
      tick(3'b010);
      check_all("ceil_hold");
    end

    // Back wall sets DirX, then a held paddle code scores exactly once
    tick(3'b100);
    check_all("backwall");
    for (int i = 0; i < 4; i++) tick(3'b001);
    check_all("paddle_hold");
    check("paddle.score1", 32'(bus.Score), 32'd1);

    // Start while playing is ignored
    pulse_start();
    check_all("start_ignored");

    // First miss past the net, frozen hold, then re-serve
    run_to_miss("miss1");
    check_all("miss1");
    check("miss1.x634", 32'(bus.XCord), 32'd634);
    hold_and_serve("hold1");

    // Stale net code near the serve point does not count
    tick(3'b011);
    check_all("stale_net");
    check("stale_net.x318", 32'(bus.XCord), 32'd318);

    // Second miss: Y rides down to the zero clamp on the way
    run_to_miss("miss2");
    check_all("miss2");
    check("miss2.y0", 32'(bus.YCord), 32'd0);
    hold_and_serve("hold2");

    // Third miss ends the game; ticks then leave everything frozen
    run_to_miss("miss3");
    check_all("gameover");
    check("gameover.flag", 32'(bus.GameOver), 32'd1);
    tick(3'b000);
    check_all("gameover_frozen");

    // Restart from game over
    pulse_start();
    msc = 0; mmi = 0; mgo = 0;
    model_serve();
    check_all("restart");

    tick(3'b100);
    tick(3'b001);
    check_all("restart_score");

    // Reset in the middle of the settle window
    bus.ColOut = 3'b000;
    pulse_tick();
    @(posedge Clk);
    @(posedge Clk); #1 Rst_n = 1'b0;
    #1;
    mx = 320; my = 232; mdx = 0; mdy = 0; msc = 0; mmi = 0; mplay = 0; mgo = 0;
    check_all("mid_reset");
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_all("mid_reset_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
